pc_ctrl: RTL
============

Name: pc_ctrl

Overview:
Program-counter and fetch-control block for the single-issue core; the consumer of the ALU's branch decision (jump_now) and JALR target.
- Holds the PC and drives the synchronous instruction-memory address.
- Resolves sequential, branch, JALR and DONE redirects, inserts the one-cycle flush bubble after a redirect, and counts retired instructions.

Parameters:
IMEM_ADDR_W, 10, width of the PC in instruction-word addresses.
RESET_PC, 0, PC value loaded on reset.
OFFSET_W, 8, width of the signed branch offset field.

Ports:
clk  input  1  core clock
n_reset  input  1  asynchronous active-low reset
stall_i  input  1  hold PC and all state this cycle
branch_i  input  1  current instruction is BEQZ/BNEQZ/BGTZ/BLTZ
jump_now_i  input  1  ALU branch decision; only meaningful when branch_i=1
offset_i  input  OFFSET_W  signed branch offset, in words, relative to pc_o
jalr_i  input  1  current instruction is JALR
jalr_addr_i  input  32  ALU result (rs) for JALR; low IMEM_ADDR_W bits used
done_i  input  1  current instruction is DONE
imem_addr_o  output  IMEM_ADDR_W  address presented to synchronous imem (data returns next cycle)
pc_o  output  IMEM_ADDR_W  PC of the instruction currently in execute
link_o  output  IMEM_ADDR_W  pc_o+1, JALR link value
instr_valid_o  output  1  instruction in execute is real (not a bubble)
flush_o  output  1  squash the instruction returned by imem this cycle
halted_o  output  1  core has executed DONE
retired_o  output  32  retired-instruction count, saturating

Behaviour:
- States: BOOT, RUN, FLUSH, HALT. Reset forces BOOT asynchronously; only reset leaves HALT.
- Reset values:
  - pc_o=RESET_PC, imem_addr_o=RESET_PC, link_o=RESET_PC+1.
  - instr_valid_o=0, flush_o=0, halted_o=0, retired_o=0.
- BOOT: imem_addr_o=RESET_PC for one cycle, instr_valid_o=0; go to RUN next cycle.
- RUN: instr_valid_o=1. Each cycle with stall_i=0, pick next PC by priority:
  - done_i → go to HALT; PC frozen.
  - jalr_i → next=jalr_addr_i[IMEM_ADDR_W-1:0]; go to FLUSH.
  - branch_i & jump_now_i → next=pc_o+sext(offset_i); go to FLUSH.
  - otherwise next=pc_o+1; stay in RUN.
- Next-PC arithmetic is modulo 2^IMEM_ADDR_W; wrap-around is legal and silent.
- imem_addr_o is combinationally the selected next PC, so imem data lines up with the updated pc_o one cycle later.
- FLUSH (exactly one cycle):
  - flush_o=1, instr_valid_o=0.
  - Branch, JALR and DONE inputs are ignored.
  - Then go to RUN with pc_o = redirect target.
- stall_i=1 in any state except HALT:
  - No state, PC or counter change; imem_addr_o re-presents pc_o.
  - Redirect inputs are ignored.
  - A stall during FLUSH extends FLUSH.
- jump_now_i is X whenever branch_i=0. It must be gated by branch_i before use; no X may reach pc_o or imem_addr_o.
- retired_o increments by 1 on each RUN cycle with stall_i=0, including the DONE instruction. It saturates at 32'hFFFF_FFFF.
- HALT: halted_o=1, instr_valid_o=0, flush_o=0. pc_o holds the DONE address and retired_o is frozen.
- Simultaneous jalr_i and branch_i, or done_i with either, is legal; resolve by the priority above.
- Reset asserted mid-FLUSH or mid-HALT returns all outputs to reset values immediately.

Decomposition:
- Shared package: pc_state_e enum (BOOT, RUN, FLUSH, HALT) and the RESET_PC default constant, next to instruction_s.
- One sub-module: pc_next_sel, a combinational priority mux plus offset sign-extension and adder.

Test Plan:
- Reset then 4 free cycles → imem_addr_o 0,1,2,3,4; pc_o 0,0,1,2,3; instr_valid_o 0,1,1,1,1; retired_o=3 on cycle 4.
- At pc_o=5, branch_i=1, jump_now_i=1, offset_i=-3 → next cycle flush_o=1, pc_o=2; one cycle later instr_valid_o=1. Same stimulus with jump_now_i=0 → pc_o=6, no flush. branch_i=0 with jump_now_i=X → pc_o advances by 1, no X on outputs.
- IMEM_ADDR_W=10, pc_o=10'h3FF, sequential → pc_o=0. JALR with jalr_addr_i=32'h0000_0C05 → pc_o=10'h005, link_o was 10'h000.
- stall_i=1 for 3 cycles with branch_i=1, jump_now_i=1 → pc_o and retired_o unchanged, flush_o=0. Release with branch still asserted → redirect taken once.
- done_i=1 together with jalr_i=1 at pc_o=7 → halted_o=1, pc_o=7, retired_o frozen; deassert n_reset mid-HALT → all outputs return to reset values asynchronously.
- Force retired_o to 32'hFFFF_FFFE, run 3 cycles → retired_o reads FFFF_FFFF and stays there.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared types and constants for the program-counter / fetch-control block.
//   pc_state_e       : fetch-control state (BOOT, RUN, FLUSH, HALT)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   RETIRED_W        : width of the retired-instruction counter
//   instruction_s    : redirect-relevant decode bits of the instruction in execute
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pc_state_e;

    localparam int unsigned RESET_PC_DEFAULT = 0;
    localparam int unsigned RETIRED_W        = 32;

    // Control-flow decode of the instruction currently in execute.
    // jump_now is only meaningful while branch is set.
    typedef struct packed {
        logic done;
        logic jalr;
        logic branch;
        logic jump_now;
    } instruction_s;

endpackage

// File: rtl/pc_ctrl_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC priority mux: DONE > JALR > taken branch > sequential.
// Ports:
//   pc          in  : PC of the instruction in execute
//   instr       in  : control-flow decode bits (instruction_s)
//   offset      in  : signed branch offset in words
//   jalr_target in  : JALR destination, already truncated to PC width
//   next_pc     out : selected next PC (modulo 2^IMEM_ADDR_W)
//   redirect    out : next PC is a non-sequential redirect (needs a bubble)
//   halt        out : instruction is DONE; PC freezes
// -----------------------------------------------------------------------------
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 10,
    parameter int unsigned OFFSET_W    = 8
) (
    input  logic [IMEM_ADDR_W-1:0] pc,
    input  instruction_s           instr,
    input  logic [OFFSET_W-1:0]    offset,
    input  logic [IMEM_ADDR_W-1:0] jalr_target,
    output logic [IMEM_ADDR_W-1:0] next_pc,
    output logic                   redirect,
    output logic                   halt
);

    logic [IMEM_ADDR_W-1:0] offset_ext;
    logic                   taken;

    generate
        if (OFFSET_W < IMEM_ADDR_W) begin : g_sext
            assign offset_ext = {{(IMEM_ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
        end else begin : g_trunc
            // Offset at least as wide as the PC: modulo arithmetic only needs the low bits.
            assign offset_ext = offset[IMEM_ADDR_W-1:0];
        end
    endgenerate

    // jump_now is undefined when branch is low; the AND keeps it out of the datapath.
    assign taken = instr.branch & instr.jump_now;

    always_comb begin
        next_pc  = pc + IMEM_ADDR_W'(1);
        redirect = 1'b0;
        halt     = 1'b0;
        if (instr.done) begin
            next_pc = pc;
            halt    = 1'b1;
        end else if (instr.jalr) begin
            next_pc  = jalr_target;
            redirect = 1'b1;
        end else if (taken) begin
            next_pc  = pc + offset_ext;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
// Program counter and fetch control for the single-issue core.
// Ports:
//   clk, n_reset   : clock, asynchronous active-low reset
//   stall_i        : hold PC and all state this cycle
//   branch_i       : conditional branch in execute; jump_now_i its ALU decision
//   offset_i       : signed branch offset (words) relative to pc_o
//   jalr_i         : JALR in execute; jalr_addr_i its target (low bits used)
//   done_i         : DONE in execute
//   imem_addr_o    : address to synchronous imem (data returns next cycle)
//   pc_o, link_o   : PC of instruction in execute and pc_o+1
//   instr_valid_o  : instruction in execute is real
//   flush_o        : squash the instruction imem returns this cycle
//   halted_o       : core has executed DONE
//   retired_o      : saturating retired-instruction count
// -----------------------------------------------------------------------------
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W = 10,
    parameter int unsigned RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned OFFSET_W    = 8
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   stall_i,
    input  logic                   branch_i,
    input  logic                   jump_now_i,
    input  logic [OFFSET_W-1:0]    offset_i,
    input  logic                   jalr_i,
    input  logic [31:0]            jalr_addr_i,
    input  logic                   done_i,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    output logic [IMEM_ADDR_W-1:0] pc_o,
    output logic [IMEM_ADDR_W-1:0] link_o,
    output logic                   instr_valid_o,
    output logic                   flush_o,
    output logic                   halted_o,
    output logic [RETIRED_W-1:0]   retired_o
);

    localparam logic [IMEM_ADDR_W-1:0] RESET_PC_W = IMEM_ADDR_W'(RESET_PC);

    pc_state_e              state_reg, state_next;
    logic [IMEM_ADDR_W-1:0] pc_reg, pc_next;
    logic [RETIRED_W-1:0]   retired_reg, retired_next;

    instruction_s           instr;
    logic [IMEM_ADDR_W-1:0] sel_pc;
    logic                   sel_redirect;
    logic                   sel_halt;

    assign instr.done     = done_i;
    assign instr.jalr     = jalr_i;
    assign instr.branch   = branch_i;
    assign instr.jump_now = jump_now_i;

    generate
        if (IMEM_ADDR_W < 32) begin : g_jalr_hi
            // Upper JALR address bits are outside the instruction memory.
            logic unused_jalr_hi;
            assign unused_jalr_hi = ^jalr_addr_i[31:IMEM_ADDR_W];
        end
    endgenerate

    pc_next_sel #(
        .IMEM_ADDR_W (IMEM_ADDR_W),
        .OFFSET_W    (OFFSET_W)
    ) u_next_sel (
        .pc          (pc_reg),
        .instr       (instr),
        .offset      (offset_i),
        .jalr_target (jalr_addr_i[IMEM_ADDR_W-1:0]),
        .next_pc     (sel_pc),
        .redirect    (sel_redirect),
        .halt        (sel_halt)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg   <= BOOT;
            pc_reg      <= RESET_PC_W;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        retired_next  = retired_reg;
        imem_addr_o   = pc_reg;   // stalls, bubbles and HALT re-present the current PC
        instr_valid_o = 1'b0;
        flush_o       = 1'b0;
        halted_o      = 1'b0;
        unique case (state_reg)
            BOOT: begin
                imem_addr_o = RESET_PC_W;
                if (!stall_i) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                instr_valid_o = 1'b1;
                if (!stall_i) begin
                    // Presenting the selected PC now aligns imem data with pc_o next cycle.
                    imem_addr_o  = sel_pc;
                    pc_next      = sel_pc;
                    retired_next = (retired_reg == '1) ? retired_reg
                                                       : retired_reg + RETIRED_W'(1);
                    if (sel_halt) begin
                        state_next = HALT;
                    end else if (sel_redirect) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // pc_reg already holds the redirect target; this cycle fetches it
                // while the stale word from the old path is squashed.
                flush_o = 1'b1;
                if (!stall_i) begin
                    state_next = RUN;
                end
            end
            HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign pc_o      = pc_reg;
    assign link_o    = pc_reg + IMEM_ADDR_W'(1);
    assign retired_o = retired_reg;

endmodule
